// File: rtl/bram_load_ctrl.sv
// Frame load/readback controller for a simple dual-port BRAM with 1-cycle read latency.
// Optional sticky error flag for ignored requests: define BRAM_LOAD_CTRL_ERR_EN.
module bram_load_ctrl #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 784
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  rd_start,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [BIT_DEPTH-1:0]  s_data,
  output logic                  s_ready,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [BIT_DEPTH-1:0]  bram_data_in,
  output logic                  bram_rd_en,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [BIT_DEPTH-1:0]  bram_data_out,
  output logic                  m_valid,
  output logic [BIT_DEPTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  frame_ready
`ifdef BRAM_LOAD_CTRL_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, READ} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;

  assign s_ready      = (state_q == LOAD);
  assign bram_wr_en   = s_valid & s_ready;
  assign bram_wr_addr = wr_cnt_q;
  assign bram_data_in = s_data;
  assign bram_rd_en   = (state_q == READ);
  assign bram_rd_addr = rd_cnt_q;
  assign frame_ready  = (state_q == FULL);
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  // BRAM output is only meaningful in the cycle after a read was issued.
  assign m_data       = m_valid_q ? bram_data_out : '0;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    m_valid_d = bram_rd_en;
    m_last_d  = bram_rd_en && (rd_cnt_q == LAST_ADDR);
    if (abort) begin
      state_d  = IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
          end
        end
        LOAD: begin
          if (bram_wr_en) begin
            if (wr_cnt_q == LAST_ADDR) begin
              state_d  = FULL;
              wr_cnt_d = '0;
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (load_start) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
          end else if (rd_start) begin
            state_d  = READ;
            rd_cnt_d = '0;
          end
        end
        READ: begin
          if (rd_cnt_q == LAST_ADDR) begin
            state_d  = FULL;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef BRAM_LOAD_CTRL_ERR_EN
  logic err_q, err_d;
  logic ignored;

  assign err = err_q;

  // Requests that the current state drops on the floor.
  always_comb begin
    ignored = 1'b0;
    case (state_q)
      IDLE:    ignored = rd_start;
      LOAD:    ignored = rd_start;
      READ:    ignored = rd_start | load_start;
      default: ignored = 1'b0;
    endcase
    err_d = abort ? 1'b0 : (err_q | ignored);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_bram_load_ctrl.sv
// Self-checking bench for bram_load_ctrl: control table, scoreboarded load/read frames,
// abort and mid-load reset sequences. Honours BRAM_LOAD_CTRL_ERR_EN for the err port.
module tb_bram_load_ctrl;

   localparam int BD    = 8;
   localparam int AW    = 10;
   localparam int DEPTH = 784;

   logic          clk;
   logic          rst;
   logic          loadStart;
   logic          rdStart;
   logic          abortReq;
   logic          sValid;
   logic [BD-1:0] sData;
   logic          sReady;
   logic          bramWrEn;
   logic [AW-1:0] bramWrAddr;
   logic [BD-1:0] bramDataIn;
   logic          bramRdEn;
   logic [AW-1:0] bramRdAddr;
   logic [BD-1:0] bramDataOut;
   logic          mValid;
   logic [BD-1:0] mData;
   logic          mLast;
   logic          frameReady;
`ifdef BRAM_LOAD_CTRL_ERR_EN
   logic          err;
`endif

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [BD-1:0] data;
   } WrExp;

   typedef struct {
      logic [BD-1:0] data;
      logic          last;
   } RdExp;

   WrExp wrQ[$];
   RdExp rdQ[$];

   logic [BD-1:0] mem [0:(1<<AW)-1];

   bram_load_ctrl #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (loadStart),
      .rd_start      (rdStart),
      .abort         (abortReq),
      .s_valid       (sValid),
      .s_data        (sData),
      .s_ready       (sReady),
      .bram_wr_en    (bramWrEn),
      .bram_wr_addr  (bramWrAddr),
      .bram_data_in  (bramDataIn),
      .bram_rd_en    (bramRdEn),
      .bram_rd_addr  (bramRdAddr),
      .bram_data_out (bramDataOut),
      .m_valid       (mValid),
      .m_data        (mData),
      .m_last        (mLast),
      .frame_ready   (frameReady)
`ifdef BRAM_LOAD_CTRL_ERR_EN
      ,
      .err           (err)
`endif
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM with a registered read port, as the controller expects.
   always @(posedge clk) begin
      if (bramWrEn) mem[bramWrAddr] <= bramDataIn;
      if (bramRdEn) bramDataOut <= mem[bramRdAddr];
   end

   // Hard stop in case some bounded wait is itself broken.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ld, input logic rd, input logic ab);
      loadStart = ld;
      rdStart   = rd;
      abortReq  = ab;
   endtask

   function automatic logic [BD-1:0] patternOf(input int i, input int pat);
      return (pat == 0) ? BD'(i) : BD'(i * 3 + 17);
   endfunction

   // Expected read stream for one whole stored frame.
   task automatic pushFrame(input int pat);
      RdExp e;
      for (int i = 0; i < DEPTH; i++) begin
         e.data = patternOf(i, pat);
         e.last = (i == DEPTH - 1);
         rdQ.push_back(e);
      end
   endtask

   // Waits for m_last; returns cycles elapsed since the rd_start cycle (caller already at T+2).
   task automatic waitLast(output int n);
      n = 2;
      while (!mLast && n < 2000) begin
         tick();
         n++;
      end
   endtask

   // Scoreboard: compare every BRAM write and every output word against the queues.
   initial begin
      WrExp w;
      RdExp r;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (bramWrEn) begin
               if (wrQ.size() == 0) begin
                  checkOutput("unexpected_write", 32'(bramWrEn), 32'd0);
               end else begin
                  w = wrQ.pop_front();
                  checkOutput("wr_addr", 32'(bramWrAddr), 32'(w.addr));
                  checkOutput("wr_data", 32'(bramDataIn), 32'(w.data));
               end
            end
            if (mValid) begin
               if (rdQ.size() == 0) begin
                  checkOutput("unexpected_m_valid", 32'(mValid), 32'd0);
               end else begin
                  r = rdQ.pop_front();
                  checkOutput("m_data", 32'(mData), 32'(r.data));
                  checkOutput("m_last", 32'(mLast), 32'(r.last));
               end
            end else begin
               checkOutput("m_last_without_valid", 32'(mLast), 32'd0);
            end
         end
      end
   end

   typedef struct {
      logic ld;
      logic rd;
      logic ab;
      logic expSReady;
      logic expFrameReady;
      logic expRdEn;
      logic expErr;
   } CtrlVec;

   // Main sequence.
   initial begin
      CtrlVec vecs[5];
      WrExp   w;
      int     n;

      vecs[0] = '{ld:0, rd:1, ab:0, expSReady:0, expFrameReady:0, expRdEn:0, expErr:1};
      vecs[1] = '{ld:1, rd:0, ab:0, expSReady:1, expFrameReady:0, expRdEn:0, expErr:1};
      vecs[2] = '{ld:0, rd:1, ab:0, expSReady:1, expFrameReady:0, expRdEn:0, expErr:1};
      vecs[3] = '{ld:0, rd:0, ab:1, expSReady:0, expFrameReady:0, expRdEn:0, expErr:0};
      vecs[4] = '{ld:0, rd:0, ab:0, expSReady:0, expFrameReady:0, expRdEn:0, expErr:0};

      applyStimulus(0, 0, 0);
      sValid = 1'b0;
      sData  = '0;
      rst    = 1'b1;
      #22;
      checkOutput("rst_s_ready", 32'(sReady), 0);
      checkOutput("rst_frame_ready", 32'(frameReady), 0);
      checkOutput("rst_m_valid", 32'(mValid), 0);
      checkOutput("rst_m_last", 32'(mLast), 0);
      checkOutput("rst_m_data", 32'(mData), 0);
      checkOutput("rst_wr_en", 32'(bramWrEn), 0);
      checkOutput("rst_rd_en", 32'(bramRdEn), 0);
      checkOutput("rst_wr_addr", 32'(bramWrAddr), 0);
      checkOutput("rst_rd_addr", 32'(bramRdAddr), 0);
`ifdef BRAM_LOAD_CTRL_ERR_EN
      checkOutput("rst_err", 32'(err), 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Control table: ignored requests in IDLE/LOAD, abort back to IDLE.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].ld, vecs[i].rd, vecs[i].ab);
         tick();
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("vec%0d_s_ready", i), 32'(sReady), 32'(vecs[i].expSReady));
         checkOutput($sformatf("vec%0d_frame_ready", i), 32'(frameReady), 32'(vecs[i].expFrameReady));
         checkOutput($sformatf("vec%0d_rd_en", i), 32'(bramRdEn), 32'(vecs[i].expRdEn));
`ifdef BRAM_LOAD_CTRL_ERR_EN
         checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].expErr));
`endif
      end

      // Continuous load of a full frame.
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         sValid = 1'b1;
         sData  = patternOf(i, 0);
         w.addr = AW'(i);
         w.data = sData;
         wrQ.push_back(w);
         tick();
      end
      sValid = 1'b0;
      checkOutput("load_frame_ready", 32'(frameReady), 1);
      checkOutput("load_s_ready_after", 32'(sReady), 0);
      checkOutput("load_wrq_empty", 32'(wrQ.size()), 0);

      // Read with latency measurement, then back-to-back frame from the first FULL cycle.
      applyStimulus(0, 1, 0);
      pushFrame(0);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("read_t1_rd_en", 32'(bramRdEn), 1);
      checkOutput("read_t1_m_valid", 32'(mValid), 0);
      checkOutput("read_t1_frame_ready", 32'(frameReady), 0);
      tick();
      checkOutput("read_t2_m_valid", 32'(mValid), 1);
      waitLast(n);
      checkOutput("read_last_latency", 32'(n), 32'(DEPTH + 1));
      checkOutput("read_end_frame_ready", 32'(frameReady), 1);

      applyStimulus(0, 1, 0);
      pushFrame(0);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("b2b_gap_m_valid", 32'(mValid), 0);
      tick();
      checkOutput("b2b_t2_m_valid", 32'(mValid), 1);
      waitLast(n);
      checkOutput("b2b_last_latency", 32'(n), 32'(DEPTH + 1));
      tick();
      checkOutput("b2b_rdq_empty", 32'(rdQ.size()), 0);

      // Overwrite from FULL with s_valid toggling; extra s_valid after the end must not write.
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         sValid = 1'b1;
         sData  = patternOf(i, 1);
         w.addr = AW'(i);
         w.data = sData;
         wrQ.push_back(w);
         tick();
         if (i < DEPTH - 1) begin
            sValid = 1'b0;
            sData  = 8'hA5;
            tick();
         end
      end
      checkOutput("toggle_frame_ready", 32'(frameReady), 1);
      for (int i = 0; i < 4; i++) begin
         sValid = (i % 2 == 0);
         tick();
      end
      sValid = 1'b0;
      checkOutput("toggle_wrq_empty", 32'(wrQ.size()), 0);

      // Abort while issuing read address 100.
      applyStimulus(0, 1, 0);
      pushFrame(1);
      tick();
      applyStimulus(0, 0, 0);
      n = 0;
      while (bramRdAddr != AW'(100) && n < 200) begin
         tick();
         n++;
      end
      checkOutput("abort_reach_addr100", 32'(bramRdAddr), 100);
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("abort_rd_en", 32'(bramRdEn), 0);
      checkOutput("abort_frame_ready", 32'(frameReady), 0);
      checkOutput("abort_inflight_m_valid", 32'(mValid), 1);
      tick();
      checkOutput("abort_m_valid_done", 32'(mValid), 0);
      checkOutput("abort_words_left", 32'(rdQ.size()), 32'(DEPTH - 101));
      rdQ.delete();
      applyStimulus(0, 1, 0);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("post_abort_rd_ignored", 32'(bramRdEn), 0);
      tick();
      checkOutput("post_abort_m_valid", 32'(mValid), 0);
      checkOutput("post_abort_frame_ready", 32'(frameReady), 0);
`ifdef BRAM_LOAD_CTRL_ERR_EN
      checkOutput("post_abort_err", 32'(err), 1);
`endif

      // Asynchronous reset in the middle of a load at word 50.
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      for (int i = 0; i < 50; i++) begin
         sValid = 1'b1;
         sData  = patternOf(i, 0);
         w.addr = AW'(i);
         w.data = sData;
         wrQ.push_back(w);
         tick();
      end
      sData = patternOf(50, 0);
      checkOutput("midload_addr50", 32'(bramWrAddr), 50);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_s_ready", 32'(sReady), 0);
      checkOutput("async_rst_wr_en", 32'(bramWrEn), 0);
      checkOutput("async_rst_wr_addr", 32'(bramWrAddr), 0);
      checkOutput("async_rst_frame_ready", 32'(frameReady), 0);
`ifdef BRAM_LOAD_CTRL_ERR_EN
      checkOutput("async_rst_err", 32'(err), 0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("post_rst_s_ready%0d", i), 32'(sReady), 0);
      end
      checkOutput("post_rst_wrq_empty", 32'(wrQ.size()), 0);
      sValid = 1'b0;
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("reload_s_ready", 32'(sReady), 1);
      checkOutput("reload_wr_addr", 32'(bramWrAddr), 0);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
